command_arbiter_credit_control: RTL and testbench

//  Shares the single PSL command interface among the AFU command sources: WED, read, write, prefetch_read and prefetch_write.

---
 rtl/command_arbiter_credit_control.sv | 142 ++++++++++++++
 tb/tb_command_arbiter_credit_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter_credit_control.sv
// Arbitrates the AFU command sources onto the single PSL command port and
// tracks PSL command credits (loaded from room, consumed per issue, returned per response).
module command_arbiter_credit_control #(
    parameter int NUM_REQUESTERS = 5,
    parameter int CMD_WIDTH      = 128,
    parameter int CREDIT_WIDTH   = 8,
    parameter int WED_PRIORITY   = 1
) (
    input  logic                                clock,
    input  logic                                reset_in,
    input  logic                                enabled_in,
    input  logic                                room_valid_in,
    input  logic [CREDIT_WIDTH-1:0]             room_in,
    input  logic [NUM_REQUESTERS-1:0]           req_valid_in,
    input  logic [NUM_REQUESTERS*CMD_WIDTH-1:0] req_cmd_in,
    output logic [NUM_REQUESTERS-1:0]           req_grant_out,
    input  logic                                response_valid_in,
    output logic                                cmd_valid_out,
    output logic [CMD_WIDTH-1:0]                cmd_out,
    output logic [$clog2(NUM_REQUESTERS)-1:0]   cmd_src_out,
    output logic [CREDIT_WIDTH-1:0]             credits_out,
    output logic                                credit_overflow_error_out,
    output logic                                idle_out
);

    localparam int SRC_W = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state_q;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [CREDIT_WIDTH-1:0] max_credits_q;
    logic                    overflow_q, overflow_d;
    logic                    cmd_valid_q;
    logic [CMD_WIDTH-1:0]    cmd_q;
    logic [SRC_W-1:0]        cmd_src_q;

    logic                    grant_found;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        cand_idx;
    int                      cand;

    // rr_ptr never points at source 0, so the search reaches it only after N-1;
    // with WED priority it has already been served ahead of the search.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (state_q == ST_RUN && credits_q != '0) begin
            if (WED_PRIORITY != 0 && req_valid_in[0]) begin
                grant_found = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQUESTERS; k++) begin
                    cand = int'(rr_ptr_q) + k;
                    if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
                    cand_idx = SRC_W'(cand);
                    if (!grant_found && req_valid_in[cand_idx]) begin
                        grant_found = 1'b1;
                        grant_idx   = cand_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found && grant_idx != '0) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQUESTERS - 1) ? SRC_W'(1) : grant_idx + SRC_W'(1);
        end
    end

    // A simultaneous grant and response cancel; a response with nothing outstanding is an error.
    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        if (grant_found && !response_valid_in) begin
            credits_d = credits_q - CREDIT_WIDTH'(1);
        end else if (!grant_found && response_valid_in) begin
            if (credits_q == max_credits_q) overflow_d = 1'b1;
            else                            credits_d  = credits_q + CREDIT_WIDTH'(1);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= SRC_W'(1);
            credits_q     <= '0;
            max_credits_q <= '0;
            overflow_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
            cmd_src_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            credits_q   <= credits_d;
            overflow_q  <= overflow_d;
            cmd_valid_q <= grant_found;
            if (grant_found) begin
                cmd_q     <= req_cmd_in[int'(grant_idx)*CMD_WIDTH +: CMD_WIDTH];
                cmd_src_q <= grant_idx;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enabled_in) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (room_valid_in) begin
                        credits_q     <= room_in;
                        max_credits_q <= room_in;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enabled_in) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (credits_q == max_credits_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_grant_out             = grant_found ? (NUM_REQUESTERS'(1) << grant_idx) : '0;
    assign cmd_valid_out             = cmd_valid_q;
    assign cmd_out                   = cmd_q;
    assign cmd_src_out               = cmd_src_q;
    assign credits_out               = credits_q;
    assign credit_overflow_error_out = overflow_q;
    assign idle_out                  = (state_q != ST_RUN) && (credits_q == max_credits_q) && !cmd_valid_q;

endmodule

// File: tb/tb_command_arbiter_credit_control.sv
// Table-driven bench for command_arbiter_credit_control: each row is one clock cycle of
// inputs plus the outputs expected during that cycle, followed by a hand-written rotation run.
module tb_command_arbiter_credit_control;

    localparam int N  = 5;
    localparam int CW = 128;

    logic            clock = 1'b0;
    logic            reset_in;
    logic            enabled_in;
    logic            room_valid_in;
    logic [7:0]      room_in;
    logic [N-1:0]    req_valid_in;
    logic [N*CW-1:0] req_cmd_in;
    logic [N-1:0]    req_grant_out;
    logic            response_valid_in;
    logic            cmd_valid_out;
    logic [CW-1:0]   cmd_out;
    logic [2:0]      cmd_src_out;
    logic [7:0]      credits_out;
    logic            credit_overflow_error_out;
    logic            idle_out;

    int checks = 0;
    int errors = 0;

    command_arbiter_credit_control dut (
        .clock                     (clock),
        .reset_in                  (reset_in),
        .enabled_in                (enabled_in),
        .room_valid_in             (room_valid_in),
        .room_in                   (room_in),
        .req_valid_in              (req_valid_in),
        .req_cmd_in                (req_cmd_in),
        .req_grant_out             (req_grant_out),
        .response_valid_in         (response_valid_in),
        .cmd_valid_out             (cmd_valid_out),
        .cmd_out                   (cmd_out),
        .cmd_src_out               (cmd_src_out),
        .credits_out               (credits_out),
        .credit_overflow_error_out (credit_overflow_error_out),
        .idle_out                  (idle_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, en, rv;
        logic [7:0] room;
        logic [4:0] valid;
        logic       resp, chk;
        logic [4:0] g;
        logic       cv;
        logic [2:0] src;
        logic [7:0] cred;
        logic       idle, err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [CW-1:0] cmd_of(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h1111_1111, 64'hA5A5_0000_0000_0000 | 64'(i)};
    endfunction

    task automatic add(input logic rst, en, rv, input logic [7:0] room, input logic [4:0] valid,
                       input logic resp, chk, input logic [4:0] g, input logic cv,
                       input logic [2:0] src, input logic [7:0] cred, input logic idle, err);
        vec_t v;
        v.rst = rst; v.en = en; v.rv = rv; v.room = room; v.valid = valid; v.resp = resp;
        v.chk = chk; v.g = g; v.cv = cv; v.src = src; v.cred = cred; v.idle = idle; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, enable (IDLE->LOAD), then present room for one cycle (LOAD->RUN).
    task automatic reset_and_load(input logic [7:0] room);
        add(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,    0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, room, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) req_cmd_in[i*CW +: CW] = cmd_of(i);
        reset_in = 1'b1; enabled_in = 1'b0; room_valid_in = 1'b0; room_in = '0;
        req_valid_in = '0; response_valid_in = 1'b0;

        // rst en rv room valid resp chk | grant cv src cred idle err
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        // T1: round-robin 1..4 until credits run out
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 4, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b00010, 0, 0, 4, 0, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b00100, 1, 1, 3, 0, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b01000, 1, 2, 2, 0, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b10000, 1, 3, 1, 0, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b00000, 1, 4, 0, 0, 0);
        add(0, 1, 0, 0, 5'b11110, 0, 1, 5'b00000, 0, 0, 0, 0, 0);
        // T2: WED priority over source 2
        reset_and_load(8);
        add(0, 1, 0, 0, 5'b00101, 0, 1, 5'b00001, 0, 0, 8, 0, 0);
        add(0, 1, 0, 0, 5'b00101, 0, 1, 5'b00001, 1, 0, 7, 0, 0);
        add(0, 1, 0, 0, 5'b00101, 0, 1, 5'b00001, 1, 0, 6, 0, 0);
        add(0, 1, 0, 0, 5'b00100, 0, 1, 5'b00100, 1, 0, 5, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 1, 2, 4, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 4, 0, 0);
        // T3: single credit, grant and response in the same cycle
        reset_and_load(1);
        add(0, 1, 0, 0, 5'b01000, 1, 1, 5'b01000, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 5'b01000, 0, 1, 5'b01000, 1, 3, 1, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 1, 3, 0, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 1, 0, 0);
        // T4: response with nothing outstanding sets sticky error
        reset_and_load(2);
        add(0, 1, 0, 0, 5'b00000, 1, 1, 5'b00000, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 2, 0, 1);
        // T5: issue 3, drop enable in the cycle of the 3rd grant, drain, back to IDLE and reload
        reset_and_load(3);
        add(0, 1, 0, 0, 5'b00010, 0, 1, 5'b00010, 0, 0, 3, 0, 0);
        add(0, 1, 0, 0, 5'b00010, 0, 1, 5'b00010, 1, 1, 2, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 0, 1, 5'b00010, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 0, 1, 5'b00000, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 1, 1, 5'b00000, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 1, 1, 5'b00000, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 1, 1, 5'b00000, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 5'b00010, 0, 1, 5'b00000, 0, 0, 3, 1, 0);
        add(0, 0, 0, 0, 5'b00010, 0, 1, 5'b00000, 0, 0, 3, 1, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 3, 1, 0);
        add(0, 1, 1, 5, 5'b00000, 0, 1, 5'b00000, 0, 0, 3, 1, 0);
        add(0, 1, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 5, 0, 0);
        // T6: reset mid-RUN with 2 outstanding and the error set
        reset_and_load(4);
        add(0, 1, 0, 0, 5'b00000, 1, 1, 5'b00000, 0, 0, 4, 0, 0);
        add(0, 1, 0, 0, 5'b00110, 0, 1, 5'b00010, 0, 0, 4, 0, 1);
        add(0, 1, 0, 0, 5'b00110, 0, 1, 5'b00100, 1, 1, 3, 0, 1);
        add(1, 1, 0, 0, 5'b00110, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 5'b00000, 0, 1, 5'b00000, 0, 0, 0, 1, 0);

        tick();
        for (int r = 0; r < vecs.size(); r++) begin
            reset_in          = vecs[r].rst;
            enabled_in        = vecs[r].en;
            room_valid_in     = vecs[r].rv;
            room_in           = vecs[r].room;
            req_valid_in      = vecs[r].valid;
            response_valid_in = vecs[r].resp;
            #1;
            if (vecs[r].chk) begin
                check($sformatf("row%0d grant", r), CW'(req_grant_out), CW'(vecs[r].g));
                check($sformatf("row%0d cmd_valid", r), CW'(cmd_valid_out), CW'(vecs[r].cv));
                check($sformatf("row%0d credits", r), CW'(credits_out), CW'(vecs[r].cred));
                check($sformatf("row%0d idle", r), CW'(idle_out), CW'(vecs[r].idle));
                check($sformatf("row%0d overflow", r), CW'(credit_overflow_error_out), CW'(vecs[r].err));
                if (vecs[r].cv) begin
                    check($sformatf("row%0d cmd_src", r), CW'(cmd_src_out), CW'(vecs[r].src));
                    check($sformatf("row%0d cmd", r), cmd_out, cmd_of(int'(vecs[r].src)));
                end
            end
            tick();
        end

        // Rotation between sources 1 and 4 with 6 credits: 1,4,1,4,1,4 then nothing.
        reset_in = 1'b1; enabled_in = 1'b0; req_valid_in = '0; response_valid_in = 1'b0;
        tick();
        reset_in = 1'b0; enabled_in = 1'b1;
        tick();
        room_valid_in = 1'b1; room_in = 8'd6;
        tick();
        room_valid_in = 1'b0; req_valid_in = 5'b10010;
        for (int k = 0; k < 8; k++) begin
            logic [4:0] exp_g;
            int         prev_src;
            exp_g    = (k < 6) ? ((k % 2 == 0) ? 5'b00010 : 5'b10000) : 5'b00000;
            prev_src = ((k - 1) % 2 == 0) ? 1 : 4;
            #1;
            check($sformatf("rot%0d grant", k), CW'(req_grant_out), CW'(exp_g));
            check($sformatf("rot%0d credits", k), CW'(credits_out), CW'(6 - ((k < 6) ? k : 6)));
            if (k >= 1 && k <= 6) begin
                check($sformatf("rot%0d cmd_valid", k), CW'(cmd_valid_out), CW'(1));
                check($sformatf("rot%0d cmd_src", k), CW'(cmd_src_out), CW'(prev_src));
            end
            tick();
        end
        check("rot_end cmd_valid", CW'(cmd_valid_out), CW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
